// File: rtl/ex_stage_if.sv
// Signal bundle between the ID/EX register, the execute stage and the EX/MEM consumers.
// The master side drives the decoded instruction; the slave side is the execute stage.
interface ex_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             i_inst_vld;
  logic             i_rd_wren;
  logic             i_mem_wren;
  logic             i_opa_sel;
  logic             i_opb_sel;
  logic [3:0]       i_alu_op;
  logic [1:0]       i_wb_sel;
  logic [3:0]       i_lsu_op;
  logic             i_branch;
  logic             i_jump;
  logic [2:0]       i_funct3;
  logic             i_br_un;
  logic [XLEN-1:0]  i_rs1_data;
  logic [XLEN-1:0]  i_rs2_data;
  logic [XLEN-1:0]  i_immgen;
  logic [XLEN-1:0]  i_pc;
  logic [XLEN-1:0]  i_pc_four;
  logic [31:0]      i_instr;
  logic             i_mem_stall;

  logic             o_pc_sel;
  logic [XLEN-1:0]  o_pc_target;
  logic             o_flush;
  logic             o_stall_ex;
  logic [XLEN-1:0]  o_alu_mem;
  logic [XLEN-1:0]  o_rs2_mem;
  logic [XLEN-1:0]  o_pc_four_mem;
  logic [31:0]      o_instr_mem;
  logic [8:0]       o_ctrl_mem;
  logic [CNT_W-1:0] o_br_cnt;
  logic [CNT_W-1:0] o_br_taken_cnt;

  modport master (
    output i_inst_vld, i_rd_wren, i_mem_wren, i_opa_sel, i_opb_sel, i_alu_op,
           i_wb_sel, i_lsu_op, i_branch, i_jump, i_funct3, i_br_un,
           i_rs1_data, i_rs2_data, i_immgen, i_pc, i_pc_four, i_instr, i_mem_stall,
    input  o_pc_sel, o_pc_target, o_flush, o_stall_ex, o_alu_mem, o_rs2_mem,
           o_pc_four_mem, o_instr_mem, o_ctrl_mem, o_br_cnt, o_br_taken_cnt
  );

  modport slave (
    input  i_inst_vld, i_rd_wren, i_mem_wren, i_opa_sel, i_opb_sel, i_alu_op,
           i_wb_sel, i_lsu_op, i_branch, i_jump, i_funct3, i_br_un,
           i_rs1_data, i_rs2_data, i_immgen, i_pc, i_pc_four, i_instr, i_mem_stall,
    output o_pc_sel, o_pc_target, o_flush, o_stall_ex, o_alu_mem, o_rs2_mem,
           o_pc_four_mem, o_instr_mem, o_ctrl_mem, o_br_cnt, o_br_taken_cnt
  );
endinterface

// File: rtl/ex_stage.sv
// RV32I execute stage: ALU, branch resolution, fetch redirect and the EX/MEM register.
// EX/MEM and the branch statistics freeze while the load/store stage is busy.
module ex_stage #(
  parameter int          XLEN      = 32,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic      i_clk,
  input logic      i_reset_ex,
  ex_stage_if.slave ex
);

  localparam logic [8:0] CTRL_BUBBLE = 9'b1_0_0_00_0000;

  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_next;
  logic            cond;
  logic            rs_eq;
  logic            rs_lt;
  logic            advance;
  logic            taken;
  logic [8:0]      ctrl_next;

  logic [XLEN-1:0] alu_reg;
  logic [XLEN-1:0] rs2_reg;
  logic [XLEN-1:0] pc_four_reg;
  logic [31:0]     instr_reg;
  logic [8:0]      ctrl_reg;

  logic [1:0]            cnt_inc;
  logic [1:0][CNT_W-1:0] cnt_val;

  assign opa   = ex.i_opa_sel ? ex.i_pc : ex.i_rs1_data;
  assign opb   = ex.i_opb_sel ? ex.i_immgen : ex.i_rs2_data;
  assign shamt = opb[4:0];

  always_comb begin
    alu_next = '0;
    case (ex.i_alu_op)
      4'd0:    alu_next = opa + opb;
      4'd1:    alu_next = opa - opb;
      4'd2:    alu_next = opa << shamt;
      4'd3:    alu_next = {{(XLEN-1){1'b0}}, ($signed(opa) < $signed(opb))};
      4'd4:    alu_next = {{(XLEN-1){1'b0}}, (opa < opb)};
      4'd5:    alu_next = opa ^ opb;
      4'd6:    alu_next = opa >> shamt;
      4'd7:    alu_next = $signed(opa) >>> shamt;
      4'd8:    alu_next = opa | opb;
      4'd9:    alu_next = opa & opb;
      4'd10:   alu_next = opb;
      default: alu_next = '0;
    endcase
  end

  // LT/GE signedness is chosen by i_br_un alone; funct3[1] is ignored.
  assign rs_eq = (ex.i_rs1_data == ex.i_rs2_data);
  assign rs_lt = ex.i_br_un ? (ex.i_rs1_data < ex.i_rs2_data)
                            : ($signed(ex.i_rs1_data) < $signed(ex.i_rs2_data));

  always_comb begin
    cond = 1'b0;
    case (ex.i_funct3)
      3'b000:          cond = rs_eq;
      3'b001:          cond = !rs_eq;
      3'b100, 3'b110:  cond = rs_lt;
      3'b101, 3'b111:  cond = !rs_lt;
      default:         cond = 1'b0;
    endcase
  end

  assign advance = !ex.i_mem_stall;
  assign taken   = ex.i_inst_vld & ex.i_branch & cond;

  // Redirect is suppressed while stalled; the held ID/EX replays it once the stall drops.
  assign ex.o_pc_sel    = i_reset_ex & advance & ex.i_inst_vld & (taken | ex.i_jump);
  assign ex.o_flush     = ex.o_pc_sel;
  assign ex.o_pc_target = {alu_next[XLEN-1:1], 1'b0};
  assign ex.o_stall_ex  = ex.i_mem_stall;

  assign ctrl_next = {ex.i_inst_vld, ex.i_rd_wren, ex.i_mem_wren, ex.i_wb_sel, ex.i_lsu_op};

  always_ff @(posedge i_clk or negedge i_reset_ex) begin
    if (!i_reset_ex) begin
      alu_reg     <= '0;
      rs2_reg     <= '0;
      pc_four_reg <= '0;
      instr_reg   <= NOP_INSTR;
      ctrl_reg    <= CTRL_BUBBLE;
    end else if (advance) begin
      alu_reg     <= alu_next;
      rs2_reg     <= ex.i_rs2_data;
      pc_four_reg <= ex.i_pc_four;
      instr_reg   <= ex.i_instr;
      ctrl_reg    <= ctrl_next;
    end
  end

  // Index 0: branches resolved, index 1: branches taken.
  assign cnt_inc = {advance & taken, advance & ex.i_inst_vld & ex.i_branch};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge i_clk or negedge i_reset_ex) begin
        if (!i_reset_ex) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi]) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
      assign cnt_val[gi] = cnt_reg;
    end
  endgenerate

  assign ex.o_alu_mem      = alu_reg;
  assign ex.o_rs2_mem      = rs2_reg;
  assign ex.o_pc_four_mem  = pc_four_reg;
  assign ex.o_instr_mem    = instr_reg;
  assign ex.o_ctrl_mem     = ctrl_reg;
  assign ex.o_br_cnt       = cnt_val[0];
  assign ex.o_br_taken_cnt = cnt_val[1];

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: EX/MEM expectations are queued as each instruction is
// driven and popped after the clock edge that should load them.
module tb_ex_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [31:0] pcf;
    logic [31:0] instr;
    logic [8:0]  ctrl;
  } exmem_t;

  localparam exmem_t RESET_EXP = {32'h0, 32'h0, 32'h0, 32'h0000_0013, 9'h100};

  logic clk = 1'b0;
  logic rst_n;

  ex_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W), .NOP_INSTR(32'h0000_0013)) dut (
    .i_clk      (clk),
    .i_reset_ex (rst_n),
    .ex         (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  exmem_t           exp_q[$];
  exmem_t           exp_v;
  exmem_t           last_exp;
  exmem_t           got;
  logic [CNT_W-1:0] exp_br;
  logic [CNT_W-1:0] exp_taken;

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a << b[4:0];
      4'd3:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:    r = (a < b) ? 32'd1 : 32'd0;
      4'd5:    r = a ^ b;
      4'd6:    r = a >> b[4:0];
      4'd7:    r = $signed(a) >>> b[4:0];
      4'd8:    r = a | b;
      4'd9:    r = a & b;
      4'd10:   r = b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic exmem_t cur_exp(input logic [31:0] alu);
    exmem_t e;
    e.alu   = alu;
    e.rs2   = bus.i_rs2_data;
    e.pcf   = bus.i_pc_four;
    e.instr = bus.i_instr;
    e.ctrl  = {bus.i_inst_vld, bus.i_rd_wren, bus.i_mem_wren, bus.i_wb_sel, bus.i_lsu_op};
    return e;
  endfunction

  function automatic exmem_t dut_out();
    return {bus.o_alu_mem, bus.o_rs2_mem, bus.o_pc_four_mem, bus.o_instr_mem, bus.o_ctrl_mem};
  endfunction

  task automatic set_idle();
    bus.i_inst_vld  = 1'b0;
    bus.i_rd_wren   = 1'b0;
    bus.i_mem_wren  = 1'b0;
    bus.i_opa_sel   = 1'b0;
    bus.i_opb_sel   = 1'b0;
    bus.i_alu_op    = 4'd0;
    bus.i_wb_sel    = 2'd0;
    bus.i_lsu_op    = 4'd0;
    bus.i_branch    = 1'b0;
    bus.i_jump      = 1'b0;
    bus.i_funct3    = 3'd0;
    bus.i_br_un     = 1'b0;
    bus.i_rs1_data  = '0;
    bus.i_rs2_data  = '0;
    bus.i_immgen    = '0;
    bus.i_pc        = '0;
    bus.i_pc_four   = '0;
    bus.i_instr     = 32'h0000_0013;
    bus.i_mem_stall = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    bus.i_inst_vld = 1'b1;
    bus.i_jump     = 1'b1;
    #2;
    checks++;
    if (bus.o_pc_sel !== 1'b0 || bus.o_flush !== 1'b0) begin
      failures++;
      $display("FAIL reset_pc_sel: pc_sel=%b flush=%b required 0/0", bus.o_pc_sel, bus.o_flush);
    end
    tick();
    tick();
    got = dut_out();
    checks++;
    if (got !== RESET_EXP) begin
      failures++;
      $display("FAIL reset_exmem: got=%h required=%h", got, RESET_EXP);
    end
    checks++;
    if (bus.o_br_cnt !== '0 || bus.o_br_taken_cnt !== '0) begin
      failures++;
      $display("FAIL reset_cnt: br=%0d taken=%0d required 0/0", bus.o_br_cnt, bus.o_br_taken_cnt);
    end
    $display("txn reset: exmem=%h", got);
    rst_n = 1'b1;
    set_idle();
    last_exp  = RESET_EXP;
    exp_br    = '0;
    exp_taken = '0;
  endtask

  task automatic test_alu();
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    set_idle();
    bus.i_inst_vld = 1'b1;
    bus.i_rd_wren  = 1'b1;
    bus.i_wb_sel   = 2'd1;
    bus.i_rs1_data = 32'hFFFF_FFF0;
    bus.i_rs2_data = 32'h1234_5678;
    bus.i_immgen   = 32'h20;
    bus.i_opb_sel  = 1'b1;
    bus.i_alu_op   = 4'd0;
    bus.i_pc_four  = 32'h0000_0044;
    bus.i_instr    = 32'h0205_0513;
    exp_q.push_back(cur_exp(32'h0000_0010));
    tick();
    got = dut_out(); exp_v = exp_q.pop_front(); last_exp = exp_v;
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL alu_add: got=%h required=%h", got, exp_v);
    end
    $display("txn alu_add: alu=%h", got.alu);

    bus.i_alu_op = 4'd7;
    bus.i_immgen = 32'h4;
    exp_q.push_back(cur_exp(32'hFFFF_FFFF));
    tick();
    got = dut_out(); exp_v = exp_q.pop_front(); last_exp = exp_v;
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL alu_sra: got=%h required=%h", got, exp_v);
    end
    $display("txn alu_sra: alu=%h", got.alu);

    for (int i = 0; i < 20; i++) begin
      op = 4'($urandom_range(0, 15));
      bus.i_alu_op   = op;
      bus.i_rs1_data = $urandom;
      bus.i_rs2_data = $urandom;
      bus.i_immgen   = $urandom;
      bus.i_pc       = $urandom;
      bus.i_pc_four  = bus.i_pc + 32'd4;
      bus.i_opa_sel  = 1'($urandom_range(0, 1));
      bus.i_opb_sel  = 1'($urandom_range(0, 1));
      bus.i_mem_wren = 1'($urandom_range(0, 1));
      bus.i_lsu_op   = 4'($urandom_range(0, 15));
      bus.i_instr    = $urandom;
      a = bus.i_opa_sel ? bus.i_pc : bus.i_rs1_data;
      b = bus.i_opb_sel ? bus.i_immgen : bus.i_rs2_data;
      #1;
      checks++;
      if (bus.o_pc_target !== (alu_ref(op, a, b) & 32'hFFFF_FFFE) || bus.o_pc_sel !== 1'b0) begin
        failures++;
        $display("FAIL alu_target op=%0d: target=%h pc_sel=%b required=%h/0", op,
                 bus.o_pc_target, bus.o_pc_sel, alu_ref(op, a, b) & 32'hFFFF_FFFE);
      end
      exp_q.push_back(cur_exp(alu_ref(op, a, b)));
      tick();
      got = dut_out(); exp_v = exp_q.pop_front(); last_exp = exp_v;
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL alu_rand op=%0d: got=%h required=%h", op, got, exp_v);
      end
      $display("txn alu op=%0d a=%h b=%h alu=%h", op, a, b, got.alu);
    end
  endtask

  task automatic test_branch();
    // {funct3, rs1, rs2, br_un, taken}
    logic [2:0]  f3_t [8] = '{3'b100, 3'b100, 3'b000, 3'b001, 3'b010, 3'b011, 3'b111, 3'b101};
    logic [31:0] r1_t [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9, 32'd9, 32'd5, 32'd1, 32'd1, 32'd3};
    logic [31:0] r2_t [8] = '{32'd1, 32'd1, 32'd9, 32'd9, 32'd5, 32'd2, 32'hFFFF_FFFF, 32'd3};
    logic        un_t [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        tk_t [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    set_idle();
    bus.i_inst_vld = 1'b1;
    bus.i_branch   = 1'b1;
    bus.i_pc       = 32'h100;
    bus.i_pc_four  = 32'h104;
    bus.i_immgen   = 32'h40;
    bus.i_opa_sel  = 1'b1;
    bus.i_opb_sel  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.i_funct3   = f3_t[i];
      bus.i_rs1_data = r1_t[i];
      bus.i_rs2_data = r2_t[i];
      bus.i_br_un    = un_t[i];
      bus.i_instr    = {20'h0, 5'(i), 7'h63};
      #1;
      checks++;
      if (bus.o_pc_sel !== tk_t[i] || bus.o_flush !== tk_t[i] || bus.o_pc_target !== 32'h140) begin
        failures++;
        $display("FAIL branch_%0d: pc_sel=%b flush=%b target=%h required=%b/%b/00000140", i,
                 bus.o_pc_sel, bus.o_flush, bus.o_pc_target, tk_t[i], tk_t[i]);
      end
      exp_q.push_back(cur_exp(32'h140));
      tick();
      exp_br++;
      if (tk_t[i]) exp_taken++;
      got = dut_out(); exp_v = exp_q.pop_front(); last_exp = exp_v;
      checks++;
      if (got !== exp_v || bus.o_br_cnt !== exp_br || bus.o_br_taken_cnt !== exp_taken) begin
        failures++;
        $display("FAIL branch_cnt_%0d: exmem=%h br=%0d taken=%0d required exmem=%h br=%0d taken=%0d",
                 i, got, bus.o_br_cnt, bus.o_br_taken_cnt, exp_v, exp_br, exp_taken);
      end
      $display("txn branch f3=%b un=%b taken=%b br=%0d tk=%0d", f3_t[i], un_t[i], tk_t[i],
               bus.o_br_cnt, bus.o_br_taken_cnt);
    end
  endtask

  task automatic test_jalr();
    set_idle();
    bus.i_inst_vld = 1'b1;
    bus.i_rd_wren  = 1'b1;
    bus.i_wb_sel   = 2'd2;
    bus.i_jump     = 1'b1;
    bus.i_rs1_data = 32'h203;
    bus.i_immgen   = 32'h0;
    bus.i_opb_sel  = 1'b1;
    bus.i_pc       = 32'h504;
    bus.i_pc_four  = 32'h508;
    bus.i_instr    = 32'h0000_8067;
    #1;
    checks++;
    if (bus.o_pc_sel !== 1'b1 || bus.o_flush !== 1'b1 || bus.o_pc_target !== 32'h202) begin
      failures++;
      $display("FAIL jalr_redirect: pc_sel=%b flush=%b target=%h required 1/1/00000202",
               bus.o_pc_sel, bus.o_flush, bus.o_pc_target);
    end
    exp_q.push_back(cur_exp(32'h203));
    tick();
    got = dut_out(); exp_v = exp_q.pop_front(); last_exp = exp_v;
    checks++;
    if (got !== exp_v || bus.o_br_cnt !== exp_br || bus.o_br_taken_cnt !== exp_taken) begin
      failures++;
      $display("FAIL jalr_exmem: exmem=%h br=%0d taken=%0d required exmem=%h br=%0d taken=%0d",
               got, bus.o_br_cnt, bus.o_br_taken_cnt, exp_v, exp_br, exp_taken);
    end
    set_idle();
    #1;
    checks++;
    if (bus.o_flush !== 1'b0) begin
      failures++;
      $display("FAIL jalr_flush_once: flush=%b required 0", bus.o_flush);
    end
    $display("txn jalr: target=00000202 br=%0d", bus.o_br_cnt);
  endtask

  task automatic test_stall();
    set_idle();
    bus.i_inst_vld  = 1'b1;
    bus.i_branch    = 1'b1;
    bus.i_funct3    = 3'b000;
    bus.i_rs1_data  = 32'h55;
    bus.i_rs2_data  = 32'h55;
    bus.i_pc        = 32'h300;
    bus.i_pc_four   = 32'h304;
    bus.i_immgen    = 32'h10;
    bus.i_opa_sel   = 1'b1;
    bus.i_opb_sel   = 1'b1;
    bus.i_instr     = 32'h0052_8863;
    bus.i_mem_stall = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      #1;
      checks++;
      if (bus.o_pc_sel !== 1'b0 || bus.o_stall_ex !== 1'b1) begin
        failures++;
        $display("FAIL stall_cycle%0d: pc_sel=%b stall_ex=%b required 0/1", c, bus.o_pc_sel,
                 bus.o_stall_ex);
      end
      tick();
      got = dut_out();
      checks++;
      if (got !== last_exp || bus.o_br_cnt !== exp_br || bus.o_br_taken_cnt !== exp_taken) begin
        failures++;
        $display("FAIL stall_hold%0d: exmem=%h br=%0d taken=%0d required exmem=%h br=%0d taken=%0d",
                 c, got, bus.o_br_cnt, bus.o_br_taken_cnt, last_exp, exp_br, exp_taken);
      end
      $display("txn stall cycle=%0d held exmem=%h", c, got);
    end
    bus.i_mem_stall = 1'b0;
    #1;
    checks++;
    if (bus.o_pc_sel !== 1'b1 || bus.o_pc_target !== 32'h310 || bus.o_stall_ex !== 1'b0) begin
      failures++;
      $display("FAIL stall_release: pc_sel=%b target=%h stall_ex=%b required 1/00000310/0",
               bus.o_pc_sel, bus.o_pc_target, bus.o_stall_ex);
    end
    exp_q.push_back(cur_exp(32'h310));
    tick();
    exp_br++;
    exp_taken++;
    got = dut_out(); exp_v = exp_q.pop_front(); last_exp = exp_v;
    checks++;
    if (got !== exp_v || bus.o_br_cnt !== exp_br || bus.o_br_taken_cnt !== exp_taken) begin
      failures++;
      $display("FAIL stall_load: exmem=%h br=%0d taken=%0d required exmem=%h br=%0d taken=%0d",
               got, bus.o_br_cnt, bus.o_br_taken_cnt, exp_v, exp_br, exp_taken);
    end
    set_idle();
    #1;
    checks++;
    if (bus.o_pc_sel !== 1'b0) begin
      failures++;
      $display("FAIL stall_once: pc_sel=%b required 0", bus.o_pc_sel);
    end
    $display("txn stall release: target=00000310 br=%0d taken=%0d", bus.o_br_cnt, bus.o_br_taken_cnt);
  endtask

  task automatic test_reset_mid();
    set_idle();
    bus.i_inst_vld = 1'b1;
    bus.i_jump     = 1'b1;
    bus.i_rs1_data = 32'h800;
    bus.i_opb_sel  = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    got = dut_out();
    checks++;
    if (got !== RESET_EXP || bus.o_pc_sel !== 1'b0 || bus.o_flush !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: exmem=%h pc_sel=%b flush=%b required exmem=%h 0/0", got,
               bus.o_pc_sel, bus.o_flush, RESET_EXP);
    end
    checks++;
    if (bus.o_br_cnt !== '0 || bus.o_br_taken_cnt !== '0) begin
      failures++;
      $display("FAIL reset_mid_cnt: br=%0d taken=%0d required 0/0", bus.o_br_cnt, bus.o_br_taken_cnt);
    end
    tick();
    got = dut_out();
    checks++;
    if (got !== RESET_EXP) begin
      failures++;
      $display("FAIL reset_mid_hold: exmem=%h required=%h", got, RESET_EXP);
    end
    $display("txn reset mid-run: exmem=%h", got);
    rst_n = 1'b1;
    set_idle();
    exp_q.delete();
    last_exp  = RESET_EXP;
    exp_br    = '0;
    exp_taken = '0;
  endtask

  task automatic test_back_to_back();
    set_idle();
    bus.i_inst_vld = 1'b1;
    bus.i_branch   = 1'b1;
    bus.i_funct3   = 3'b000;
    bus.i_rs1_data = 32'h7;
    bus.i_rs2_data = 32'h7;
    bus.i_opa_sel  = 1'b1;
    bus.i_opb_sel  = 1'b1;
    bus.i_immgen   = 32'h8;
    for (int i = 0; i < 16; i++) begin
      bus.i_pc      = 32'h1000 + 32'(4 * i);
      bus.i_pc_four = bus.i_pc + 32'd4;
      bus.i_instr   = 32'h0000_0463 | 32'(i << 20);
      exp_q.push_back(cur_exp(bus.i_pc + 32'h8));
      tick();
      exp_br++;
      exp_taken++;
      got = dut_out(); exp_v = exp_q.pop_front(); last_exp = exp_v;
      checks++;
      if (got !== exp_v || bus.o_br_cnt !== exp_br || bus.o_br_taken_cnt !== exp_taken) begin
        failures++;
        $display("FAIL b2b_%0d: exmem=%h br=%0d taken=%0d required exmem=%h br=%0d taken=%0d",
                 i, got, bus.o_br_cnt, bus.o_br_taken_cnt, exp_v, exp_br, exp_taken);
      end
      $display("txn b2b branch=%0d br=%0d taken=%0d", i, bus.o_br_cnt, bus.o_br_taken_cnt);
    end
    checks++;
    if (bus.o_br_cnt !== 4'd0 || bus.o_br_taken_cnt !== 4'd0) begin
      failures++;
      $display("FAIL cnt_wrap: br=%0d taken=%0d required 0/0", bus.o_br_cnt, bus.o_br_taken_cnt);
    end
    set_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_jalr();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
